// File: rtl/sort_pkg.sv
// Shared types and helpers for the sort front-end and sorter cores.
// Holds the loader state encoding and the one-hot check used on slot selects.
package sort_pkg;

   localparam int DEF_WIDTH = 4;
   localparam int DEF_DEPTH = 4;

   typedef enum logic [1:0] {
      FILL    = 2'd0,
      READY   = 2'd1,
      HANDOFF = 2'd2,
      BUSY    = 2'd3
   } loader_state_t;

   function automatic logic onehot_check(input logic [63:0] v);
      return (v != '0) && ((v & (v - 64'd1)) == '0);
   endfunction

endpackage

// File: rtl/sort_input_loader_sync.sv
// strobe_sync_edge: multi-stage synchronizer for an async strobe plus a
// single-cycle rising-edge pulse taken from the last synchronizer stage.
module strobe_sync_edge #(
   parameter int SYNC_FF = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic strobe,
   output logic pulse
);

   logic [SYNC_FF-1:0] chain;
   logic               prev;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         chain <= '0;
         prev  <= 1'b0;
      end else begin
         chain <= {chain[SYNC_FF-2:0], strobe};
         prev  <= chain[SYNC_FF-1];
      end
   end

   assign pulse = chain[SYNC_FF-1] & ~prev;

endmodule

// File: rtl/sort_input_loader.sv
// Operand loader in front of the sorter: async strobe capture into a slot bank
// and start/done hand-off. Define SORT_LOADER_AUTO_IDX_EN for pointer addressing.
module sort_input_loader
   import sort_pkg::*;
#(
   parameter int WIDTH   = DEF_WIDTH,
   parameter int DEPTH   = DEF_DEPTH,
   parameter int SYNC_FF = 2
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [DEPTH-1:0]       sel,
   input  logic [WIDTH-1:0]       din,
   input  logic                   wr_strobe,
   input  logic                   clear_i,
   input  logic                   go_i,
   input  logic                   sorter_done,
   output logic [DEPTH*WIDTH-1:0] data_flat,
   output logic [DEPTH-1:0]       valid_mask,
   output logic                   all_loaded,
   output logic                   start_o,
   output logic                   locked,
   output logic                   sel_err
);

   loader_state_t               state;
   logic [DEPTH-1:0][WIDTH-1:0] slots;
   logic                        wr_pulse;
   logic                        accept;
   logic                        wr_ok;
   logic [DEPTH-1:0]            wr_hot;
   logic [DEPTH-1:0]            valid_next;

   strobe_sync_edge #(
      .SYNC_FF(SYNC_FF)
   ) u_sync (
      .clk   (clk),
      .rst   (rst),
      .strobe(wr_strobe),
      .pulse (wr_pulse)
   );

`ifdef SORT_LOADER_AUTO_IDX_EN
   localparam int PW = $clog2(DEPTH);
   logic [PW-1:0] ptr;

   always_comb begin
      wr_hot = '0;
      wr_hot[ptr] = 1'b1;
      wr_ok = 1'b1;
   end
`else
   always_comb begin
      wr_hot = sel;
      wr_ok  = onehot_check(64'(sel));
   end
`endif

   // Bank is only writable while the sorter does not own it.
   always_comb begin
      accept     = wr_pulse && !clear_i &&
                   (state == FILL || state == READY);
      valid_next = valid_mask;
      if (accept && wr_ok)
         valid_next = valid_mask | wr_hot;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= FILL;
         slots      <= '0;
         valid_mask <= '0;
         all_loaded <= 1'b0;
         start_o    <= 1'b0;
         locked     <= 1'b0;
         sel_err    <= 1'b0;
`ifdef SORT_LOADER_AUTO_IDX_EN
         ptr        <= '0;
`endif
      end else begin
         start_o <= 1'b0;
         unique case (state)
            FILL, READY: begin
               if (clear_i) begin
                  valid_mask <= '0;
                  all_loaded <= 1'b0;
                  sel_err    <= 1'b0;
                  state      <= FILL;
`ifdef SORT_LOADER_AUTO_IDX_EN
                  ptr        <= '0;
`endif
               end else begin
                  if (accept) begin
                     if (wr_ok) begin
                        for (int k = 0; k < DEPTH; k++)
                           if (wr_hot[k])
                              slots[k] <= din;
`ifdef SORT_LOADER_AUTO_IDX_EN
                        ptr <= (ptr == PW'(DEPTH - 1)) ? '0 : ptr + 1'b1;
`endif
                     end else begin
                        sel_err <= 1'b1;
                     end
                  end
                  valid_mask <= valid_next;
                  all_loaded <= &valid_next;
                  // go_i only counts once READY was already reached.
                  if (state == READY && go_i) begin
                     state   <= HANDOFF;
                     start_o <= 1'b1;
                     locked  <= 1'b1;
                  end else if (&valid_next) begin
                     state <= READY;
                  end else begin
                     state <= FILL;
                  end
               end
            end
            HANDOFF: begin
               state <= BUSY;
            end
            BUSY: begin
               if (sorter_done) begin
                  state  <= READY;
                  locked <= 1'b0;
               end
            end
            default: state <= FILL;
         endcase
      end
   end

`ifdef SORT_LOADER_AUTO_IDX_EN
   assign data_flat = slots;
`else
   assign data_flat = slots;
`endif

endmodule

// File: tb/tb_sort_input_loader.sv
// Directed plus randomized bench for sort_input_loader with a slot-level
// reference model of load, clear, hand-off and busy lockout.
module tb_sort_input_loader;

   logic        clk = 1'b0;
   logic        rst;
   logic [3:0]  sel;
   logic [3:0]  din;
   logic        wr_strobe;
   logic        clear_i;
   logic        go_i;
   logic        sorter_done;
   logic [15:0] data_flat;
   logic [3:0]  valid_mask;
   logic        all_loaded;
   logic        start_o;
   logic        locked;
   logic        sel_err;

   int checks = 0;
   int errors = 0;

   logic [3:0] mslot[4];
   logic [3:0] mvalid;
   logic       merr;
   logic       mlocked;
   logic       mstart;
   int         mptr;

   always #5 clk = ~clk;

   sort_input_loader #(
      .WIDTH(4),
      .DEPTH(4),
      .SYNC_FF(2)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .sel        (sel),
      .din        (din),
      .wr_strobe  (wr_strobe),
      .clear_i    (clear_i),
      .go_i       (go_i),
      .sorter_done(sorter_done),
      .data_flat  (data_flat),
      .valid_mask (valid_mask),
      .all_loaded (all_loaded),
      .start_o    (start_o),
      .locked     (locked),
      .sel_err    (sel_err)
   );

   task automatic chk(input string tag, input logic [63:0] obs,
                      input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < 4; i++) mslot[i] = 4'h0;
      mvalid  = 4'h0;
      merr    = 1'b0;
      mlocked = 1'b0;
      mstart  = 1'b0;
      mptr    = 0;
   endtask

   // Effect of one clock edge given what the loader sees on that edge.
   task automatic model_edge(input bit wr, input logic [3:0] s,
                             input logic [3:0] d, input bit clr,
                             input bit go);
      bit full_before;
      mstart = 1'b0;
      if (mlocked) return;
      if (clr) begin
         mvalid = 4'h0;
         merr   = 1'b0;
         mptr   = 0;
         return;
      end
      full_before = (mvalid == 4'hF);
      if (wr) begin
`ifdef SORT_LOADER_AUTO_IDX_EN
         mslot[mptr]  = d;
         mvalid[mptr] = 1'b1;
         mptr         = (mptr + 1) % 4;
`else
         if ($countones(s) == 1) begin
            for (int i = 0; i < 4; i++)
               if (s[i]) begin
                  mslot[i]  = d;
                  mvalid[i] = 1'b1;
               end
         end else begin
            merr = 1'b1;
         end
`endif
      end
      if (go && full_before) begin
         mstart  = 1'b1;
         mlocked = 1'b1;
      end
   endtask

   task automatic check_all(input string tag);
      logic [15:0] packed_exp;
      for (int i = 0; i < 4; i++) packed_exp[i*4 +: 4] = mslot[i];
      chk({tag, "_data"},  64'(data_flat),  64'(packed_exp));
      chk({tag, "_valid"}, 64'(valid_mask), 64'(mvalid));
      chk({tag, "_all"},   64'(all_loaded), 64'(mvalid == 4'hF));
      chk({tag, "_lock"},  64'(locked),     64'(mlocked));
      chk({tag, "_err"},   64'(sel_err),    64'(merr));
      chk({tag, "_start"}, 64'(start_o),    64'(mstart));
   endtask

   task automatic do_write(input string tag, input logic [3:0] s,
                           input logic [3:0] d, input bit clr,
                           input bit go);
      @(posedge clk); #2;
      sel = s; din = d; wr_strobe = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      check_all({tag, "_pre"});
      clear_i = clr; go_i = go;
      @(posedge clk); #1;
      clear_i = 1'b0; go_i = 1'b0;
      model_edge(1'b1, s, d, clr, go);
      check_all(tag);
      wr_strobe = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      mstart = 1'b0;
   endtask

   task automatic do_ctrl(input string tag, input bit clr, input bit go,
                          input bit done);
      @(posedge clk); #2;
      clear_i = clr; go_i = go; sorter_done = done;
      @(posedge clk); #1;
      clear_i = 1'b0; go_i = 1'b0; sorter_done = 1'b0;
      if (done) begin
         mstart = 1'b0;
         if (mlocked) mlocked = 1'b0;
      end else begin
         model_edge(1'b0, 4'h0, 4'h0, clr, go);
      end
      check_all(tag);
      @(posedge clk); #1;
      mstart = 1'b0;
      check_all({tag, "_after"});
   endtask

   initial begin
      logic [3:0] rs;
      int         r;
      rst = 1'b1; sel = 4'h0; din = 4'h0; wr_strobe = 1'b0;
      clear_i = 1'b0; go_i = 1'b0; sorter_done = 1'b0;
      model_reset();
      repeat (3) @(posedge clk);
      #1;
      check_all("reset");
      @(posedge clk); #2;
      rst = 1'b0;

      do_write("first", 4'b0001, 4'h5, 1'b0, 1'b0);

      do_ctrl("clr0", 1'b1, 1'b0, 1'b0);
      do_write("ld0", 4'b0001, 4'h9, 1'b0, 1'b0);
      do_ctrl("go_fill", 1'b0, 1'b1, 1'b0);
      do_write("ld1", 4'b0010, 4'h3, 1'b0, 1'b0);
      do_write("ld2", 4'b0100, 4'hC, 1'b0, 1'b0);
      do_write("ld3", 4'b1000, 4'h1, 1'b0, 1'b0);
      chk("bank_val", 64'(data_flat), 64'h1C39);
      do_ctrl("go", 1'b0, 1'b1, 1'b0);

      do_write("busy_wr", 4'b0010, 4'hF, 1'b0, 1'b0);
      do_ctrl("busy_clr", 1'b1, 1'b0, 1'b0);
      do_ctrl("done", 1'b0, 1'b0, 1'b1);

      do_write("bad_sel", 4'b0110, 4'h7, 1'b0, 1'b0);
      do_ctrl("clr1", 1'b1, 1'b0, 1'b0);

      @(posedge clk); #2;
      sel = 4'b0100; din = 4'hA; wr_strobe = 1'b1;
      repeat (10) @(posedge clk);
      #1;
      model_edge(1'b1, 4'b0100, 4'hA, 1'b0, 1'b0);
      check_all("hold_a");
      din = 4'hB;
      repeat (40) @(posedge clk);
      #1;
      check_all("hold_b");
      wr_strobe = 1'b0;
      repeat (4) @(posedge clk);

      do_write("clr_beats_wr", 4'b0001, 4'h6, 1'b1, 1'b0);

      for (int i = 0; i < 4; i++)
         do_write("fill", 4'(1 << i), 4'($urandom_range(0, 15)),
                  1'b0, 1'b0);
      do_write("wr_go", 4'b0100, 4'hE, 1'b0, 1'b1);
      do_ctrl("done2", 1'b0, 1'b0, 1'b1);

      for (int n = 0; n < 30; n++) begin
         r = $urandom_range(0, 9);
         unique case (r % 3)
            0: rs = 4'(1 << $urandom_range(0, 3));
            1: rs = 4'($urandom_range(0, 15));
            default: rs = 4'(1 << $urandom_range(0, 3));
         endcase
         if (r < 6)
            do_write("rnd_wr", rs, 4'($urandom_range(0, 15)),
                     ($urandom_range(0, 9) == 0),
                     ($urandom_range(0, 3) == 0));
         else if (r == 6)
            do_ctrl("rnd_go", 1'b0, 1'b1, 1'b0);
         else if (r == 7)
            do_ctrl("rnd_clr", 1'b1, 1'b0, 1'b0);
         else
            do_ctrl("rnd_done", 1'b0, 1'b0, 1'b1);
      end
      do_ctrl("end_done", 1'b0, 1'b0, 1'b1);

`ifdef SORT_LOADER_AUTO_IDX_EN
      do_ctrl("auto_clr", 1'b1, 1'b0, 1'b0);
      for (int i = 1; i <= 5; i++)
         do_write("auto", 4'h0, 4'(i), 1'b0, 1'b0);
      chk("auto_bank", 64'(data_flat), 64'h4325);
      do_ctrl("auto_clr2", 1'b1, 1'b0, 1'b0);
`endif

      do_ctrl("pre_rst_clr", 1'b1, 1'b0, 1'b0);
      for (int i = 0; i < 4; i++)
         do_write("refill", 4'(1 << i), 4'($urandom_range(1, 15)),
                  1'b0, 1'b0);
      @(posedge clk); #2;
      go_i = 1'b1;
      @(posedge clk); #1;
      go_i = 1'b0;
      model_edge(1'b0, 4'h0, 4'h0, 1'b0, 1'b1);
      check_all("handoff");
      #2;
      rst = 1'b1;
      #1;
      model_reset();
      check_all("async_rst");
      @(posedge clk); #2;
      rst = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check_all("post_rst");

      $display("Simulation finished: %0d checks, %0d errors",
               checks, errors);
      $finish;
   end

endmodule
